// File: rtl/rom_loader.sv
// rom_loader: boot-time loader copying ROM images into target RAM slots and filling the rest.
// Writes use a valid/ready handshake; init signals load complete and gates CPU reset.
module rom_loader #(
    parameter int AW = 19,
    parameter int SLOTW = 15,
    parameter int IMAGES = 3,
    parameter int DW = 8,
    parameter logic [DW-1:0] FILL = 8'hFF,
    parameter int RDLAT = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        power,
    input  logic                        restart,
    input  logic [IMAGES-1:0]           skip,
    output logic [AW-SLOTW-1:0]         srcSel,
    output logic [SLOTW-1:0]            srcA,
    input  logic [DW-1:0]               srcQ,
    output logic                        iniW,
    input  logic                        iniRdy,
    output logic [AW-1:0]               iniA,
    output logic [DW-1:0]               iniD,
    output logic                        busy,
    output logic                        init
);
    localparam int SW = AW - SLOTW;
    localparam int SLOTS = 1 << SW;
    localparam int CW = $clog2(RDLAT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   addr;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   slot;
    logic [SLOTS-1:0] skip_ext;
    logic            is_img;

    assign slot = addr[AW-1:SLOTW];
    // Slots beyond IMAGES read as never-skipped fill slots
    assign skip_ext = SLOTS'(skip);
    assign is_img = int'(slot) < IMAGES;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= '0;
            cnt    <= '0;
            srcSel <= '0;
            srcA   <= '0;
            iniW   <= 1'b0;
            iniA   <= '0;
            iniD   <= '0;
            busy   <= 1'b0;
            init   <= 1'b0;
        end else if (restart && state != IDLE) begin
            state <= ADDR;
            addr  <= '0;
            iniW  <= 1'b0;
            busy  <= 1'b1;
            init  <= 1'b0;
        end else if (!power && state != DONE) begin
            state <= IDLE;
            addr  <= '0;
            iniW  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ADDR;
                    addr  <= '0;
                    busy  <= 1'b1;
                end
                ADDR: begin
                    if (skip_ext[slot]) begin
                        if (&slot) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            init  <= 1'b1;
                        end else begin
                            addr <= {slot + 1'b1, {SLOTW{1'b0}}};
                        end
                    end else if (is_img) begin
                        srcSel <= slot;
                        srcA   <= addr[SLOTW-1:0];
                        cnt    <= '0;
                        state  <= READ;
                    end else begin
                        iniD  <= FILL;
                        iniA  <= addr;
                        iniW  <= 1'b1;
                        state <= WRITE;
                    end
                end
                READ: begin
                    if (cnt == CW'(RDLAT - 1)) begin
                        iniD  <= srcQ;
                        iniA  <= addr;
                        iniW  <= 1'b1;
                        state <= WRITE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (iniRdy) begin
                        iniW <= 1'b0;
                        if (&addr) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            init  <= 1'b1;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven loads plus hand sequences for restart, power gating and reset.
module tb_rom_loader;
    localparam int AW = 6, SLOTW = 4, IMAGES = 2, DW = 8, RDLAT = 1;

    logic clk = 1'b0, rst = 1'b1, power = 1'b0, restart = 1'b0, iniRdy = 1'b1;
    logic [IMAGES-1:0] skip = '0;
    logic [1:0] srcSel;
    logic [3:0] srcA;
    logic [7:0] srcQ, iniD;
    logic [5:0] iniA;
    logic iniW, busy, init;

    int checks = 0, errors = 0;
    bit rnd = 0, rdy_force = 1, stab_en = 0;
    logic [13:0] beats[$];
    logic pend = 1'b0;
    logic [13:0] held;

    typedef struct {
        logic [1:0] sk;
        bit rn;
        int n;
        int fa;
        int fd;
        int cyc;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;

    // ROM model: word = image*16 + offset, combinational
    assign srcQ = {2'b00, srcSel, srcA};

    rom_loader #(.AW(AW), .SLOTW(SLOTW), .IMAGES(IMAGES), .DW(DW), .FILL(8'hFF), .RDLAT(RDLAT)) dut (
        .clock(clk), .reset(rst), .power(power), .restart(restart), .skip(skip),
        .srcSel(srcSel), .srcA(srcA), .srcQ(srcQ), .iniW(iniW), .iniRdy(iniRdy),
        .iniA(iniA), .iniD(iniD), .busy(busy), .init(init)
    );

    initial forever begin
        @(posedge clk);
        #2;
        iniRdy = rnd ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    always @(negedge clk) begin
        if (iniW && iniRdy) beats.push_back({iniA, iniD});
        if (stab_en && pend) begin
            checks++;
            if ({iniW, iniA, iniD} !== {1'b1, held}) begin
                errors++;
                $display("FAIL hold_stable: got W=%0d A=%0d D=%0h expected W=1 A=%0d D=%0h",
                         iniW, iniA, iniD, held[13:8], held[7:0]);
            end
        end
        pend = iniW && !iniRdy;
        held = {iniA, iniD};
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("load_completes", int'(init), 1);
    endtask

    task automatic check_beats(input string n, input logic [1:0] sk);
        logic [13:0] exp[$];
        int s;
        for (int a = 0; a < 64; a++) begin
            s = a / 16;
            if (s < IMAGES && sk[s]) continue;
            exp.push_back({6'(a), (s < IMAGES) ? 8'(a) : 8'hFF});
        end
        chk({n, "_count"}, beats.size(), exp.size());
        for (int i = 0; i < exp.size() && i < beats.size(); i++)
            chk($sformatf("%s_beat%0d", n, i), int'(beats[i]), int'(exp[i]));
    endtask

    task automatic wait_beats(input int k);
        int i = 0;
        while (beats.size() < k && i < 1000) begin
            @(negedge clk);
            i++;
        end
        chk("beats_reached", int'(beats.size() >= k), 1);
    endtask

    task automatic wait_w(input logic v);
        int i = 0;
        while (iniW !== v && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("iniW_reached", int'(iniW), int'(v));
    endtask

    initial begin
        int n;
        // Cycle counts include the IDLE->ADDR edge that sees power high
        vt[0] = '{2'b00, 1'b0, 64, 0, 0, 161};
        vt[1] = '{2'b01, 1'b0, 48, 16, 16, 114};
        vt[2] = '{2'b10, 1'b0, 48, 0, 0, 114};
        vt[3] = '{2'b11, 1'b0, 32, 32, 255, 67};
        vt[4] = '{2'b00, 1'b1, 64, 0, 0, 0};

        @(negedge clk);
        chk("rst_srcSel", int'(srcSel), 0);
        chk("rst_srcA", int'(srcA), 0);
        chk("rst_iniW", int'(iniW), 0);
        chk("rst_iniA", int'(iniA), 0);
        chk("rst_iniD", int'(iniD), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_init", int'(init), 0);

        for (int v = 0; v < 5; v++) begin
            rst = 1'b1;
            power = 1'b0;
            skip = vt[v].sk;
            rnd = vt[v].rn;
            stab_en = vt[v].rn;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            beats.delete();
            @(negedge clk);
            power = 1'b1;
            wait_init(n);
            if (vt[v].cyc != 0) chk($sformatf("v%0d_cycles", v), n, vt[v].cyc);
            chk($sformatf("v%0d_nbeats", v), beats.size(), vt[v].n);
            chk($sformatf("v%0d_first_a", v), beats.size() > 0 ? int'(beats[0][13:8]) : -1, vt[v].fa);
            chk($sformatf("v%0d_first_d", v), beats.size() > 0 ? int'(beats[0][7:0]) : -1, vt[v].fd);
            check_beats($sformatf("v%0d", v), vt[v].sk);
        end
        rnd = 0;
        stab_en = 0;
        @(negedge clk);

        // restart in DONE
        restart = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_done_init", int'(init), 0);
        chk("restart_done_busy", int'(busy), 1);
        @(negedge clk);
        restart = 1'b0;
        beats.delete();
        wait_init(n);
        check_beats("reload", 2'b00);

        // restart mid-load while a beat is pending
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        beats.delete();
        wait_beats(21);
        wait_w(1'b1);
        restart = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_busy_iniW", int'(iniW), 0);
        chk("restart_busy_busy", int'(busy), 1);
        @(negedge clk);
        restart = 1'b0;
        beats.delete();
        wait_init(n);
        check_beats("after_restart", 2'b00);

        // power low mid-load
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        beats.delete();
        wait_beats(11);
        wait_w(1'b0);
        power = 1'b0;
        @(posedge clk);
        #1;
        chk("pwr_off_iniW", int'(iniW), 0);
        chk("pwr_off_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("pwr_off_idle_busy", int'(busy), 0);
        chk("pwr_off_idle_init", int'(init), 0);
        beats.delete();
        power = 1'b1;
        wait_init(n);
        check_beats("after_power", 2'b00);
        @(negedge clk);
        power = 1'b0;
        repeat (4) @(negedge clk);
        chk("pwr_off_done_init", int'(init), 1);
        power = 1'b1;

        // asynchronous reset while a beat is stalled
        rdy_force = 0;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_w(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_iniW", int'(iniW), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_init", int'(init), 0);
        @(negedge clk);
        rst = 1'b0;
        rdy_force = 1;
        beats.delete();
        wait_init(n);
        check_beats("after_reset", 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
